// File: rtl/urvsoc_stim.sv
// rtl/urvsoc_stim.sv - stimulus generator for urvsoc benches: reset stretch, UART byte stream, IRQ pulses
//
// Ports:
//   CLK100MHZ      system clock
//   resetn         asynchronous active-low reset
//   rst_out_n      stretched active-low reset towards the SoC
//   tx_data_i      byte to queue for serial transmission
//   tx_valid_i     push request; a push happens on tx_valid_i && tx_ready_o
//   tx_ready_o     FIFO has room and the SoC is out of reset
//   uart_rxd_o     serial line into the SoC receiver, idle high
//   fifo_level_o   number of bytes currently queued
//   busy_o         a frame is on the line or bytes are still queued
//   irq_req_i      per-channel pulse trigger
//   irq_len_i      pulse length in clocks (0 is treated as 1)
//   irq_o          interrupt lines towards the SoC
//
// Build option: define URVSOC_STIM_PARITY_EN to append an even-parity bit (8E1 framing);
// without it the line carries 8N1 frames.

module urvsoc_stim #(
    parameter int G_CLK_DIV      = 868,
    parameter int G_FIFO_DEPTH   = 16,
    parameter int G_IRQ_CHANNELS = 8,
    parameter int G_RST_CYCLES   = 16
) (
    input  logic                          CLK100MHZ,
    input  logic                          resetn,
    output logic                          rst_out_n,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          uart_rxd_o,
    output logic [$clog2(G_FIFO_DEPTH):0] fifo_level_o,
    output logic                          busy_o,
    input  logic [G_IRQ_CHANNELS-1:0]     irq_req_i,
    input  logic [7:0]                    irq_len_i,
    output logic [G_IRQ_CHANNELS-1:0]     irq_o
);

    localparam int AW = $clog2(G_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (G_CLK_DIV > 2) ? $clog2(G_CLK_DIV) : 1;
    localparam int RW = $clog2(G_RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Reset stretch
    // ------------------------------------------------------------------
    logic [RW-1:0] rst_cnt_q;
    logic          rst_out_q;

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            rst_cnt_q <= '0;
            rst_out_q <= 1'b0;
        end else if (!rst_out_q) begin
            // Release happens on the G_RST_CYCLES-th edge after resetn rises.
            if (rst_cnt_q == RW'(G_RST_CYCLES - 1)) begin
                rst_out_q <= 1'b1;
            end else begin
                rst_cnt_q <= rst_cnt_q + RW'(1);
            end
        end
    end

    assign rst_out_n = rst_out_q;

    // ------------------------------------------------------------------
    // TX byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [G_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push;
    logic          pop;
    logic [7:0]    head_byte;
    state_t        state_q;

    assign tx_ready_o = (level_q < LW'(G_FIFO_DEPTH)) && rst_out_q;
    assign push       = tx_valid_i && tx_ready_o;
    // The UART pulls the next byte only from IDLE, so a pop never races an active frame.
    assign pop        = (state_q == S_IDLE) && (level_q != '0) && rst_out_q;
    assign head_byte  = fifo_mem[rd_ptr_q];

    always_ff @(posedge CLK100MHZ) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign fifo_level_o = level_q;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          line_q;
    logic          div_end;

    assign div_end = (div_q == DW'(G_CLK_DIV - 1));

`ifdef URVSOC_STIM_PARITY_EN
    logic par_q;
`endif

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
`ifdef URVSOC_STIM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    line_q <= 1'b1;
                    div_q  <= '0;
                    if (pop) begin
                        shift_q <= head_byte;
                        line_q  <= 1'b0;
                        state_q <= S_START;
`ifdef URVSOC_STIM_PARITY_EN
                        par_q   <= ^head_byte;
`endif
                    end
                end
                S_START: begin
                    if (div_end) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        line_q  <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_DATA: begin
                    if (div_end) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef URVSOC_STIM_PARITY_EN
                            line_q  <= par_q;
                            state_q <= S_PARITY;
`else
                            line_q  <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            // shift_q[1] is the next bit once the register shifts right.
                            bit_q   <= bit_q + 3'd1;
                            line_q  <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_PARITY: begin
                    if (div_end) begin
                        div_q   <= '0;
                        line_q  <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_STOP: begin
                    if (div_end) begin
                        div_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    line_q  <= 1'b1;
                end
            endcase
        end
    end

    assign uart_rxd_o = line_q;
    assign busy_o     = (state_q != S_IDLE) || (level_q != '0);

    // ------------------------------------------------------------------
    // IRQ pulse channels
    // ------------------------------------------------------------------
    logic [7:0]                irq_cnt_q [G_IRQ_CHANNELS];
    logic [7:0]                irq_cnt_d [G_IRQ_CHANNELS];
    logic [G_IRQ_CHANNELS-1:0] irq_q;
    logic [7:0]                len_eff;

    assign len_eff = (irq_len_i == 8'd0) ? 8'd1 : irq_len_i;

    always_comb begin
        for (int k = 0; k < G_IRQ_CHANNELS; k++) begin
            irq_cnt_d[k] = irq_cnt_q[k];
            if (rst_out_q && irq_req_i[k]) begin
                irq_cnt_d[k] = len_eff;
            end else if (irq_cnt_q[k] != 8'd0) begin
                irq_cnt_d[k] = irq_cnt_q[k] - 8'd1;
            end
        end
    end

    // irq_q mirrors (counter != 0) but is taken from the next-state value so the
    // line is a flop output with no extra cycle of delay.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < G_IRQ_CHANNELS; k++) begin
                irq_cnt_q[k] <= 8'd0;
            end
            irq_q <= '0;
        end else begin
            for (int k = 0; k < G_IRQ_CHANNELS; k++) begin
                irq_cnt_q[k] <= irq_cnt_d[k];
                irq_q[k]     <= (irq_cnt_d[k] != 8'd0);
            end
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_urvsoc_stim.sv
// tb/tb_urvsoc_stim.sv - directed self-checking bench for urvsoc_stim

module tb_urvsoc_stim;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int NCH     = 8;
    localparam int RSTC    = 16;
`ifdef URVSOC_STIM_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic           rst_out_n;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           uart_rxd;
    logic [2:0]     fifo_level;
    logic           busy;
    logic [NCH-1:0] irq_req;
    logic [7:0]     irq_len;
    logic [NCH-1:0] irq;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;
    int saw_full = 0;
    int max_lvl  = 0;

    urvsoc_stim #(
        .G_CLK_DIV      (CLK_DIV),
        .G_FIFO_DEPTH   (DEPTH),
        .G_IRQ_CHANNELS (NCH),
        .G_RST_CYCLES   (RSTC)
    ) dut (
        .CLK100MHZ    (clk),
        .resetn       (resetn),
        .rst_out_n    (rst_out_n),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .uart_rxd_o   (uart_rxd),
        .fifo_level_o (fifo_level),
        .busy_o       (busy),
        .irq_req_i    (irq_req),
        .irq_len_i    (irq_len),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line samples, one per clock, for a whole frame carrying b.
    function automatic logic [63:0] frame_exp(input logic [7:0] b);
        logic [15:0] fb;
        logic [63:0] e;
        fb      = '1;
        fb[0]   = 1'b0;
        fb[8:1] = b;
`ifdef URVSOC_STIM_PARITY_EN
        fb[9]   = ^b;
`endif
        e = '0;
        for (int i = 0; i < NB * CLK_DIV; i++) begin
            e[i] = fb[i / CLK_DIV];
        end
        return e;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int t;
        t        = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (1) begin
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (tx_ready !== ((fifo_level < 3'd4) && rst_out_n)) viol++;
            if (fifo_level == 3'd4 && !tx_ready) saw_full++;
            if (tx_ready || t >= 400) break;
            @(negedge clk);
            t++;
        end
        check("push_timeout", (t < 400), 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic recv_frame(input logic [7:0] b, input string tag, output int gap);
        int          t;
        logic [63:0] obs;
        t   = 0;
        obs = '0;
        while (uart_rxd === 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        gap = t;
        for (int i = 0; i < NB * CLK_DIV; i++) begin
            obs[i] = uart_rxd;
            @(negedge clk);
        end
        check(tag, obs, frame_exp(b));
    endtask

    // Drives irq_req = mask on cycles where pat[i] is set; counts high samples on two channels.
    task automatic irq_run(input logic [7:0] len, input logic [NCH-1:0] mask, input logic [31:0] pat,
                           input int ca, input int cb, output int cnt_a, output int cnt_b,
                           output int first_a);
        cnt_a   = 0;
        cnt_b   = 0;
        first_a = -1;
        irq_len = len;
        for (int i = 0; i < 24; i++) begin
            if (irq[ca]) begin
                cnt_a++;
                if (first_a < 0) first_a = i;
            end
            if (irq[cb]) cnt_b++;
            irq_req = pat[i] ? mask : '0;
            @(negedge clk);
        end
        irq_req = '0;
    endtask

    initial begin
        int gap;
        int ca;
        int cb;
        int fa;
        int errs;
        int t;

        resetn   = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        irq_req  = '0;
        irq_len  = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_rst_out_n", rst_out_n, 0);
        check("rst_uart", uart_rxd, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);

        // Requests during the stretch must be ignored.
        irq_req = '1;
        resetn  = 1'b1;
        errs    = 0;
        for (int i = 1; i <= RSTC; i++) begin
            @(posedge clk);
            #1;
            if (rst_out_n !== (i >= RSTC)) errs++;
            if (uart_rxd !== 1'b1 || irq !== '0) errs++;
            if (i == RSTC - 1) check("stretch_edge15", rst_out_n, 0);
            if (i == RSTC) check("stretch_edge16", rst_out_n, 1);
        end
        check("stretch_seq", errs, 0);
        @(negedge clk);
        irq_req = '0;
        check("irq_ignored_in_stretch", irq, 0);
        @(negedge clk);
        check("irq_idle_after_stretch", irq, 0);

        // Single byte
        push_byte(8'hA5);
        check("level_after_push", fifo_level, 1);
        check("busy_after_push", busy, 1);
        recv_frame(8'hA5, "frame_a5", gap);
        check("busy_after_a5", busy, 0);

        // Parity-sensitive patterns
        push_byte(8'h03);
        recv_frame(8'h03, "frame_03", gap);
        check("busy_after_03", busy, 0);
        push_byte(8'h07);
        recv_frame(8'h07, "frame_07", gap);
        check("busy_after_07", busy, 0);

        // FIFO full and back-to-back
        viol     = 0;
        saw_full = 0;
        max_lvl  = 0;
        fork
            begin
                for (int k = 1; k <= 6; k++) push_byte(8'(k));
            end
            begin
                int g;
                for (int k = 1; k <= 6; k++) begin
                    recv_frame(8'(k), $sformatf("b2b_frame%0d", k), g);
                    if (k > 1) check($sformatf("b2b_gap%0d", k), g, 1);
                end
            end
        join
        check("b2b_ready_viol", viol, 0);
        check("b2b_ready_low_full", (saw_full != 0), 1);
        check("b2b_max_level", max_lvl, 4);
        check("b2b_final_level", fifo_level, 0);
        check("b2b_final_busy", busy, 0);

        // IRQ pulses
        irq_run(8'd5, 8'h81, 32'h1, 0, 7, ca, cb, fa);
        check("irq81_ch0_len", ca, 5);
        check("irq81_ch7_len", cb, 5);
        check("irq81_rise", fa, 1);
        irq_run(8'd5, 8'h81, 32'h1, 1, 6, ca, cb, fa);
        check("irq81_ch1_quiet", ca, 0);
        irq_run(8'd5, 8'h01, 32'h9, 0, 1, ca, cb, fa);
        check("irq_retrigger_len", ca, 8);
        irq_run(8'd0, 8'h01, 32'h1, 0, 1, ca, cb, fa);
        check("irq_len0_len", ca, 1);
        irq_run(8'd2, 8'h04, 32'h3F, 2, 3, ca, cb, fa);
        check("irq_held_len", ca, 7);
        check("irq_held_other", cb, 0);

        // Reset mid-frame
        push_byte(8'h3C);
        push_byte(8'h5A);
        t = 0;
        while (uart_rxd === 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_uart", uart_rxd, 1);
        check("midrst_level", fifo_level, 0);
        check("midrst_rst_out_n", rst_out_n, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (RSTC + 4) @(negedge clk);
        check("midrst_rst_out_back", rst_out_n, 1);
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if (uart_rxd !== 1'b1 || busy !== 1'b0) errs++;
            @(negedge clk);
        end
        check("midrst_no_stale", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
